// File: rtl/tx_hop_pattern_gen.sv
// Frequency-hop sequencer: steps through a host-loaded table of RF configuration codes,
// one code per tx pulse, strobing dac_io_update so the downstream controller latches each code.
module tx_hop_pattern_gen #(
    parameter int PULSE_PERIOD = 2600,
    parameter int UPD_WIDTH    = 4,
    parameter int TBL_AW       = 6
) (
    input  logic              logic_clk_in,
    input  logic              logic_rst_in,
    input  logic              tbl_wr_en,
    input  logic [TBL_AW-1:0] tbl_wr_addr,
    input  logic [7:0]        tbl_wr_data,
    input  logic [TBL_AW-1:0] hop_base_addr,
    input  logic [31:0]       slot_timer,
    input  logic [31:0]       net_slot_rfposi,
    input  logic [31:0]       net_tx_pulse_num,
    output logic [7:0]        tx_feq_cfg,
    output logic              dac_io_update,
    output logic              hop_busy,
    output logic              hop_done,
    output logic [8:0]        pulse_idx
);

    localparam int                CNT_W    = $clog2(PULSE_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PULSE_PERIOD - 1);
    localparam logic [CNT_W-1:0]  UPD_LAST = CNT_W'(UPD_WIDTH);
    localparam logic [7:0]        CFG_RST  = 8'h84;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [8:0]        n_lat;
    logic [TBL_AW-1:0] rd_addr;
    logic [7:0]        tbl [2**TBL_AW];
    logic [7:0]        rd_data;
    logic              start, period_end, last_pulse, rd_en;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        start      = (state == IDLE) && (slot_timer == net_slot_rfposi) &&
                     (net_slot_rfposi != 32'd0) && (net_tx_pulse_num[8:0] != 9'd0);
        period_end = (state == RUN) && (cnt == CNT_LAST);
        last_pulse = (pulse_idx == n_lat - 9'd1);
        rd_en      = (state == RUN) && (cnt == '0);
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (period_end && last_pulse) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge logic_clk_in) begin
        if (logic_rst_in) state <= IDLE;
        else              state <= state_nxt;
    end

    always_ff @(posedge logic_clk_in) begin
        if (logic_rst_in) begin
            tx_feq_cfg    <= CFG_RST;
            dac_io_update <= 1'b0;
            hop_busy      <= 1'b0;
            hop_done      <= 1'b0;
            pulse_idx     <= 9'd0;
            cnt           <= '0;
            n_lat         <= 9'd0;
            rd_addr       <= '0;
        end else begin
            hop_done      <= period_end && last_pulse;
            hop_busy      <= (state_nxt == RUN);
            // Registered one clock ahead so the strobe is high exactly while cnt is 2..UPD_WIDTH+1.
            dac_io_update <= (state == RUN) && (cnt != '0) && (cnt <= UPD_LAST);
            if (start) begin
                n_lat     <= net_tx_pulse_num[8:0];
                rd_addr   <= hop_base_addr;
                pulse_idx <= 9'd0;
                cnt       <= '0;
            end else if (state == RUN) begin
                if (cnt == CNT_W'(1)) tx_feq_cfg <= rd_data;
                if (period_end) begin
                    cnt <= '0;
                    if (last_pulse) begin
                        pulse_idx <= 9'd0;
                    end else begin
                        pulse_idx <= pulse_idx + 9'd1;
                        rd_addr   <= rd_addr + 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // NOTE: the table RAM and its read register are deliberately not reset; contents survive reset.
    always_ff @(posedge logic_clk_in) begin
        if (tbl_wr_en) tbl[tbl_wr_addr] <= tbl_wr_data;
        if (rd_en)     rd_data <= tbl[rd_addr];
    end

endmodule

// File: tb/tb_tx_hop_pattern_gen.sv
// Directed bench for tx_hop_pattern_gen: hand-computed cycle positions relative to the start match T.
module tb_tx_hop_pattern_gen;

    logic        logic_clk_in = 1'b0;
    logic        logic_rst_in;
    logic        tbl_wr_en;
    logic [5:0]  tbl_wr_addr;
    logic [7:0]  tbl_wr_data;
    logic [5:0]  hop_base_addr;
    logic [31:0] slot_timer;
    logic [31:0] net_slot_rfposi;
    logic [31:0] net_tx_pulse_num;
    logic [7:0]  tx_feq_cfg;
    logic        dac_io_update;
    logic        hop_busy;
    logic        hop_done;
    logic [8:0]  pulse_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int c       = 0;   // cycle number relative to the current start match T

    tx_hop_pattern_gen dut (
        .logic_clk_in     (logic_clk_in),
        .logic_rst_in     (logic_rst_in),
        .tbl_wr_en        (tbl_wr_en),
        .tbl_wr_addr      (tbl_wr_addr),
        .tbl_wr_data      (tbl_wr_data),
        .hop_base_addr    (hop_base_addr),
        .slot_timer       (slot_timer),
        .net_slot_rfposi  (net_slot_rfposi),
        .net_tx_pulse_num (net_tx_pulse_num),
        .tx_feq_cfg       (tx_feq_cfg),
        .dac_io_update    (dac_io_update),
        .hop_busy         (hop_busy),
        .hop_done         (hop_done),
        .pulse_idx        (pulse_idx)
    );

    always #5 logic_clk_in = ~logic_clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        while (c < t) begin
            @(negedge logic_clk_in);
            c++;
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = a;
        tbl_wr_data = d;
        @(negedge logic_clk_in);
        tbl_wr_en   = 1'b0;
    endtask

    // Presents the match for one cycle (cycle T); returns at the negedge inside T+1.
    task automatic start(input logic [31:0] pos, input logic [8:0] n, input logic [5:0] base);
        net_slot_rfposi  = pos;
        net_tx_pulse_num = {23'd0, n};
        hop_base_addr    = base;
        slot_timer       = pos;
        @(negedge logic_clk_in);
        slot_timer       = pos + 32'd1;
        c = 1;
    endtask

    task automatic do_reset();
        logic_rst_in = 1'b1;
        @(negedge logic_clk_in);
        logic_rst_in = 1'b0;
    endtask

    initial begin
        logic_rst_in     = 1'b1;
        tbl_wr_en        = 1'b0;
        tbl_wr_addr      = '0;
        tbl_wr_data      = '0;
        hop_base_addr    = '0;
        slot_timer       = 32'd0;
        net_slot_rfposi  = 32'd0;
        net_tx_pulse_num = 32'd0;
        repeat (3) @(negedge logic_clk_in);
        logic_rst_in = 1'b0;

        check("rst_cfg",  tx_feq_cfg,    32'h84);
        check("rst_dac",  dac_io_update, 32'd0);
        check("rst_busy", hop_busy,      32'd0);
        check("rst_done", hop_done,      32'd0);
        check("rst_idx",  pulse_idx,     32'd0);

        // 1. basic burst, N=3 from base 0
        wr(6'd0, 8'h84); wr(6'd1, 8'h85); wr(6'd2, 8'h86); wr(6'd3, 8'h87);
        start(32'd100, 9'd3, 6'd0);
        check("t1_busy_T1", hop_busy,      32'd1);
        check("t1_dac_T1",  dac_io_update, 32'd0);
        goto(2);  check("t1_dac_T2",  dac_io_update, 32'd0);
        goto(3);  check("t1_dac_T3",  dac_io_update, 32'd1);
                  check("t1_cfg_T3",  tx_feq_cfg,    32'h84);
        goto(6);  check("t1_dac_T6",  dac_io_update, 32'd1);
        goto(7);  check("t1_dac_T7",  dac_io_update, 32'd0);
        goto(2602); check("t1_cfg_hold", tx_feq_cfg, 32'h84);
                    check("t1_idx1",     pulse_idx,  32'd1);
        goto(2603); check("t1_cfg_p1",   tx_feq_cfg, 32'h85);
                    check("t1_dac_p1",   dac_io_update, 32'd1);
        goto(5203); check("t1_cfg_p2",   tx_feq_cfg, 32'h86);
                    check("t1_idx2",     pulse_idx,  32'd2);
        goto(7800); check("t1_busy_last", hop_busy, 32'd1);
                    check("t1_done_early", hop_done, 32'd0);
        goto(7801); check("t1_done",     hop_done,  32'd1);
                    check("t1_busy_off", hop_busy,  32'd0);
                    check("t1_idx_clr",  pulse_idx, 32'd0);
        goto(7802); check("t1_done_pulse", hop_done, 32'd0);
                    check("t1_cfg_keep",  tx_feq_cfg, 32'h86);

        // 2. address wrap 63 -> 0
        wr(6'd62, 8'hA1); wr(6'd63, 8'hA2); wr(6'd0, 8'hA3); wr(6'd1, 8'hA4);
        start(32'd200, 9'd4, 6'd62);
        goto(3);    check("t2_cfg0", tx_feq_cfg, 32'hA1);
        goto(2603); check("t2_cfg1", tx_feq_cfg, 32'hA2);
        goto(5203); check("t2_cfg2", tx_feq_cfg, 32'hA3);
        goto(7803); check("t2_cfg3", tx_feq_cfg, 32'hA4);
                    check("t2_idx3", pulse_idx,  32'd3);
        goto(10401); check("t2_done", hop_done, 32'd1);

        // 3. disabled start conditions
        do_reset();
        net_slot_rfposi  = 32'd0;
        net_tx_pulse_num = 32'd3;
        for (int i = 0; i < 4; i++) begin
            slot_timer = i;
            @(negedge logic_clk_in);
            check("t3_rfposi0_busy", hop_busy, 32'd0);
        end
        net_slot_rfposi  = 32'd300;
        net_tx_pulse_num = 32'h200;   // [8:0] == 0
        for (int i = 298; i < 303; i++) begin
            slot_timer = i;
            @(negedge logic_clk_in);
            check("t3_n0_busy", hop_busy, 32'd0);
        end
        repeat (6) @(negedge logic_clk_in);
        check("t3_dac", dac_io_update, 32'd0);
        check("t3_cfg", tx_feq_cfg,    32'h84);

        // 4. second match and N/base changes mid-burst; restart on the done cycle
        start(32'd400, 9'd2, 6'd0);
        goto(100);
        slot_timer       = 32'd400;
        net_tx_pulse_num = 32'd5;
        hop_base_addr    = 6'd10;
        goto(101);
        slot_timer = 32'd401;
        check("t4_busy_rematch", hop_busy,  32'd1);
        check("t4_idx_rematch",  pulse_idx, 32'd0);
        goto(2603); check("t4_cfg1",  tx_feq_cfg, 32'hA4);
        goto(5200); check("t4_busy_last", hop_busy, 32'd1);
        goto(5201); check("t4_done",  hop_done, 32'd1);
                    check("t4_busy_off", hop_busy, 32'd0);
        slot_timer       = 32'd400;
        net_tx_pulse_num = 32'd1;
        hop_base_addr    = 6'd3;
        goto(5202);
        slot_timer = 32'd401;
        c = 1;
        check("t4_restart_busy", hop_busy, 32'd1);
        check("t4_restart_done", hop_done, 32'd0);
        goto(3);    check("t4_restart_cfg", tx_feq_cfg, 32'h87);
        goto(2601); check("t4_restart_done2", hop_done, 32'd1);

        // 5. reset mid-run, then replay from preserved table
        start(32'd500, 9'd3, 6'd0);
        goto(3601); check("t5_cfg_pre", tx_feq_cfg, 32'hA4);
                    check("t5_idx_pre", pulse_idx,  32'd1);
        logic_rst_in = 1'b1;
        goto(3602);
        logic_rst_in = 1'b0;
        check("t5_cfg_rst",  tx_feq_cfg,    32'h84);
        check("t5_busy_rst", hop_busy,      32'd0);
        check("t5_idx_rst",  pulse_idx,     32'd0);
        check("t5_dac_rst",  dac_io_update, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t5_no_done", hop_done, 32'd0);
            @(negedge logic_clk_in);
        end
        start(32'd600, 9'd1, 6'd0);
        goto(3);    check("t5_replay_cfg", tx_feq_cfg, 32'hA3);
        goto(2601); check("t5_replay_done", hop_done, 32'd1);

        // 6. read-first collision and write-ahead of the next entry
        wr(6'd4, 8'h11); wr(6'd5, 8'h22);
        start(32'd700, 9'd2, 6'd4);
        tbl_wr_en   = 1'b1;   // lands on the cnt==0 read of address 4
        tbl_wr_addr = 6'd4;
        tbl_wr_data = 8'h33;
        goto(2);
        tbl_wr_en = 1'b0;
        goto(3);    check("t6_read_first", tx_feq_cfg, 32'h11);
        goto(100);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 6'd5;
        tbl_wr_data = 8'h44;
        goto(101);
        tbl_wr_en = 1'b0;
        goto(2603); check("t6_write_ahead", tx_feq_cfg, 32'h44);
        goto(5201); check("t6_done", hop_done, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
